// File: rtl/wbh_clk_switch_ctrl.sv
// Glitch-safe sequencer for the wishbone/CPU clock-control field.
// Every change gates the clocks off, applies the new selection, waits for settling, then ungates.
module wbh_clk_switch_ctrl #(
    parameter int GATE_WAIT   = 8,
    parameter int SETTLE_WAIT = 16,
    parameter int CNT_W       = 8
) (
    input  logic       mclk,
    input  logic       p_reset_n,
    input  logic [7:0] strap_clk_ctrl,
    input  logic       sw_req,
    input  logic [7:0] sw_clk_ctrl,
    output logic       clk_enb,
    output logic [7:0] cfg_clk_ctrl,
    output logic       busy,
    output logic       switch_done
);

    typedef enum logic [1:0] {
        ST_INIT     = 2'd0,
        ST_IDLE     = 2'd1,
        ST_GATE_OFF = 2'd2,
        ST_SETTLE   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] GATE_LAST   = CNT_W'(GATE_WAIT - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_WAIT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             clk_enb_q, clk_enb_d;
    logic [7:0]       cfg_q, cfg_d;
    logic [7:0]       target_q, target_d;
    logic             pend_vld_q, pend_vld_d;
    logic [7:0]       pend_val_q, pend_val_d;
    logic             sw_flag_q, sw_flag_d;
    logic             switch_done_q, switch_done_d;
    logic [7:0]       req_val;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        clk_enb_d     = clk_enb_q;
        cfg_d         = cfg_q;
        target_d      = target_q;
        pend_vld_d    = pend_vld_q;
        pend_val_d    = pend_val_q;
        sw_flag_d     = sw_flag_q;
        switch_done_d = 1'b0;
        req_val       = sw_req ? sw_clk_ctrl : pend_val_q;

        // Requests arriving mid-sequence park here; the newest one wins.
        if (sw_req && (state_q != ST_IDLE)) begin
            pend_val_d = sw_clk_ctrl;
            pend_vld_d = 1'b1;
        end

        case (state_q)
            ST_INIT: begin
                cfg_d     = strap_clk_ctrl;
                target_d  = strap_clk_ctrl;
                cnt_d     = '0;
                sw_flag_d = 1'b0;
                state_d   = ST_SETTLE;
            end
            ST_IDLE: begin
                cnt_d = '0;
                if (sw_req || pend_vld_q) begin
                    pend_vld_d = 1'b0;
                    if (req_val == cfg_q) begin
                        switch_done_d = 1'b1;
                    end else begin
                        target_d  = req_val;
                        clk_enb_d = 1'b0;
                        sw_flag_d = 1'b1;
                        state_d   = ST_GATE_OFF;
                    end
                end
            end
            ST_GATE_OFF: begin
                if (cnt_q == GATE_LAST) begin
                    cfg_d   = target_q;
                    cnt_d   = '0;
                    state_d = ST_SETTLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    clk_enb_d     = 1'b1;
                    switch_done_d = sw_flag_q;
                    cnt_d         = '0;
                    state_d       = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge mclk or negedge p_reset_n) begin
        if (!p_reset_n) begin
            state_q       <= ST_INIT;
            cnt_q         <= '0;
            clk_enb_q     <= 1'b0;
            cfg_q         <= 8'h00;
            target_q      <= 8'h00;
            pend_vld_q    <= 1'b0;
            pend_val_q    <= 8'h00;
            sw_flag_q     <= 1'b0;
            switch_done_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            clk_enb_q     <= clk_enb_d;
            cfg_q         <= cfg_d;
            target_q      <= target_d;
            pend_vld_q    <= pend_vld_d;
            pend_val_q    <= pend_val_d;
            sw_flag_q     <= sw_flag_d;
            switch_done_q <= switch_done_d;
        end
    end

    assign clk_enb      = clk_enb_q;
    assign cfg_clk_ctrl = cfg_q;
    assign switch_done  = switch_done_q;
    assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_wbh_clk_switch_ctrl.sv
// Directed bench for wbh_clk_switch_ctrl: the driver queues timestamped output events,
// a negedge monitor pops one each time any output changes and compares cycle and value.
module tb_wbh_clk_switch_ctrl;

  localparam int W = 43;  // {cycle[31:0], cfg[7:0], clk_enb, busy, switch_done}

  logic       mclk = 1'b0;
  logic       p_reset_n = 1'b0;
  logic [7:0] strap_clk_ctrl = 8'h25;
  logic       sw_req = 1'b0;
  logic [7:0] sw_clk_ctrl = 8'h00;
  logic       clk_enb;
  logic [7:0] cfg_clk_ctrl;
  logic       busy;
  logic       switch_done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit mon_en = 1'b0;
  logic [10:0] prev_out;
  logic [W-1:0] exp_q[$];

  wbh_clk_switch_ctrl dut (
    .mclk          (mclk),
    .p_reset_n     (p_reset_n),
    .strap_clk_ctrl(strap_clk_ctrl),
    .sw_req        (sw_req),
    .sw_clk_ctrl   (sw_clk_ctrl),
    .clk_enb       (clk_enb),
    .cfg_clk_ctrl  (cfg_clk_ctrl),
    .busy          (busy),
    .switch_done   (switch_done)
  );

  // clock / cycle counter
  always #5 mclk = ~mclk;
  always @(posedge mclk) cyc <= cyc + 1;

  task automatic push(input int c, input logic [7:0] cfg, input logic enb,
                      input logic bsy, input logic done);
    exp_q.push_back({32'(c), cfg, enb, bsy, done});
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // one-cycle sw_req sampled at posedge number e
  task automatic req_at(input int e, input logic [7:0] val);
    do @(negedge mclk); while (cyc < e - 1);
    sw_req = 1'b1;
    sw_clk_ctrl = val;
    @(negedge mclk);
    sw_req = 1'b0;
    sw_clk_ctrl = 8'($urandom_range(0, 255));
  endtask

  // monitor: every output change must match the next queued event
  always @(negedge mclk) begin
    logic [10:0] cur;
    logic [W-1:0] e;
    if (mon_en) begin
      cur = {cfg_clk_ctrl, clk_enb, busy, switch_done};
      if (cur !== prev_out) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event: got cyc=%0d out=%h want no change", cyc, cur);
        end else begin
          e = exp_q.pop_front();
          if ({32'(cyc), cur} !== e) begin
            errors++;
            $display("FAIL event: got cyc=%0d out=%h want cyc=%0d out=%h",
                     cyc, cur, e[42:11], e[10:0]);
          end
        end
        prev_out = cur;
      end
    end
  end

  initial begin
    int r;
    int e;
    // reset state
    repeat (3) @(negedge mclk);
    check("rst_cfg", 32'(cfg_clk_ctrl), 32'h00);
    check("rst_enb", 32'(clk_enb), 32'h0);
    check("rst_busy", 32'(busy), 32'h1);
    check("rst_done", 32'(switch_done), 32'h0);
    prev_out = {8'h00, 1'b0, 1'b1, 1'b0};
    mon_en = 1'b1;

    // power-up: strap applied at edge 1, ungate 16 cycles later, no done
    @(negedge mclk);
    r = cyc;
    push(r + 1, 8'h25, 1'b0, 1'b1, 1'b0);
    push(r + 17, 8'h25, 1'b1, 1'b0, 1'b0);
    p_reset_n = 1'b1;

    // request equal to applied value: done only
    e = r + 20;
    push(e, 8'h25, 1'b1, 1'b0, 1'b1);
    push(e + 1, 8'h25, 1'b1, 1'b0, 1'b0);
    req_at(e, 8'h25);

    // normal switch 25 -> 5A
    e = e + 5;
    push(e, 8'h25, 1'b0, 1'b1, 1'b0);
    push(e + 8, 8'h5A, 1'b0, 1'b1, 1'b0);
    push(e + 24, 8'h5A, 1'b1, 1'b0, 1'b1);
    push(e + 25, 8'h5A, 1'b1, 1'b0, 1'b0);
    req_at(e, 8'h5A);

    // switch to C3 with 11 then 33 arriving during SETTLE: only 33 follows
    e = e + 30;
    push(e, 8'h5A, 1'b0, 1'b1, 1'b0);
    push(e + 8, 8'hC3, 1'b0, 1'b1, 1'b0);
    push(e + 24, 8'hC3, 1'b1, 1'b0, 1'b1);
    push(e + 25, 8'hC3, 1'b0, 1'b1, 1'b0);
    push(e + 33, 8'h33, 1'b0, 1'b1, 1'b0);
    push(e + 49, 8'h33, 1'b1, 1'b0, 1'b1);
    push(e + 50, 8'h33, 1'b1, 1'b0, 1'b0);
    req_at(e, 8'hC3);
    req_at(e + 12, 8'h11);
    req_at(e + 14, 8'h33);

    // pending 33 overridden by a live 44 on the first IDLE cycle
    e = e + 55;
    push(e, 8'h33, 1'b0, 1'b1, 1'b0);
    push(e + 8, 8'h66, 1'b0, 1'b1, 1'b0);
    push(e + 24, 8'h66, 1'b1, 1'b0, 1'b1);
    push(e + 25, 8'h66, 1'b0, 1'b1, 1'b0);
    push(e + 33, 8'h44, 1'b0, 1'b1, 1'b0);
    push(e + 49, 8'h44, 1'b1, 1'b0, 1'b1);
    push(e + 50, 8'h44, 1'b1, 1'b0, 1'b0);
    req_at(e, 8'h66);
    req_at(e + 10, 8'h33);
    req_at(e + 25, 8'h44);

    // pending value equal to the newly applied one: done stretched to two cycles
    e = e + 55;
    push(e, 8'h44, 1'b0, 1'b1, 1'b0);
    push(e + 8, 8'h55, 1'b0, 1'b1, 1'b0);
    push(e + 24, 8'h55, 1'b1, 1'b0, 1'b1);
    push(e + 26, 8'h55, 1'b1, 1'b0, 1'b0);
    req_at(e, 8'h55);
    req_at(e + 10, 8'h55);

    // reset mid-GATE_OFF, then INIT with a new strap
    e = e + 32;
    strap_clk_ctrl = 8'h9C;
    push(e, 8'h55, 1'b0, 1'b1, 1'b0);
    req_at(e, 8'h12);
    do @(negedge mclk); while (cyc < e + 3);
    push(e + 4, 8'h00, 1'b0, 1'b1, 1'b0);
    #1 p_reset_n = 1'b0;
    #1;
    check("async_rst_cfg", 32'(cfg_clk_ctrl), 32'h00);
    check("async_rst_enb", 32'(clk_enb), 32'h0);
    check("async_rst_busy", 32'(busy), 32'h1);
    repeat (3) @(negedge mclk);
    @(negedge mclk);
    r = cyc;
    push(r + 1, 8'h9C, 1'b0, 1'b1, 1'b0);
    push(r + 17, 8'h9C, 1'b1, 1'b0, 1'b0);
    p_reset_n = 1'b1;

    // drain with a bound, then require a quiet tail
    for (int i = 0; i < 300; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge mclk);
    end
    repeat (30) @(negedge mclk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("final_cfg", 32'(cfg_clk_ctrl), 32'h9C);
    check("final_busy", 32'(busy), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
